hazard_ctrl: RTL

//  Pipeline sequencer for the fetch/decode front end. Generates stallF, stallD, flushD, flushE and stallE.

---
 rtl/hazard_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencer for the fetch/decode front end. It holds the front end
// for a few cycles after reset, interlocks load-use hazards, stalls the
// pipeline while a multicycle EX unit is busy, and inserts decode bubbles
// after a taken branch/jump redirect.
//
// Ports
//   clk          in   system clock, all state on posedge
//   reset        in   synchronous, active-high
//   id_rs1/rs2   in   decode-stage source register indices
//   id_use_rs1/2 in   decode instruction actually reads rs1/rs2
//   ex_is_load   in   EX-stage instruction is a load
//   ex_rd        in   EX-stage destination register
//   ex_busy      in   multicycle unit in EX has not finished
//   branch_sig   in   taken branch/jump resolved in EX this cycle
//   stallF       out  hold fetch PC
//   stallD       out  hold decode registers
//   stallE       out  hold EX registers
//   flushD       out  bubble into decode
//   flushE       out  bubble into EX
//   busy_err     out  sticky, ex_busy lasted BUSY_TIMEOUT consecutive cycles
//   stall_count  out  cycles with stallF=1 since reset (wraps)
//
// stall*/flush* are combinational from the registered state and the current
// inputs; busy_err and stall_count are registered.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int BOOT_CYCLES    = 2,     // >= 1
  parameter int BRANCH_BUBBLES = 1,     // 0..15
  parameter int BUSY_TIMEOUT   = 1024   // >= 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        ex_busy,
  input  logic        branch_sig,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        flushD,
  output logic        flushE,
  output logic        busy_err,
  output logic [31:0] stall_count
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int TO_W   = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_BUSY,
    S_BUBBLE
  } state_t;

  state_t              state_q, state_d;
  logic [BOOT_W-1:0]   boot_cnt_q, boot_cnt_d;
  logic [3:0]          bub_cnt_q, bub_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                busy_err_q, busy_err_d;
  logic [31:0]         stall_count_q, stall_count_d;

  logic hazard;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign hazard = ex_is_load && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    bub_cnt_d  = bub_cnt_q;
    to_cnt_d   = to_cnt_q;
    busy_err_d = busy_err_q;
    stallF     = 1'b0;
    stallD     = 1'b0;
    stallE     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        // Front end held while imem initialises; all other inputs ignored.
        {stallF, stallD, flushD, flushE} = 4'b1111;
        if (boot_cnt_q == '0) state_d = S_RUN;
        else                  boot_cnt_d = boot_cnt_q - 1'b1;
      end

      S_RUN, S_BUBBLE: begin
        if (ex_busy) begin
          {stallF, stallD, stallE} = 3'b111;
          state_d  = S_BUSY;
          to_cnt_d = TO_W'(1);
        end else if (branch_sig) begin
          {flushD, flushE} = 2'b11;
          if (BRANCH_BUBBLES > 0) begin
            state_d   = S_BUBBLE;
            bub_cnt_d = 4'(BRANCH_BUBBLES);
          end else begin
            state_d = S_RUN;
          end
        end else begin
          // Load-use outranks the bubble's flushD; the bubble still counts down.
          if (hazard) {stallF, stallD, flushE} = 3'b111;
          else if (state_q == S_BUBBLE) flushD = 1'b1;
          if (state_q == S_BUBBLE) begin
            bub_cnt_d = bub_cnt_q - 1'b1;
            if (bub_cnt_q <= 4'd1) state_d = S_RUN;
          end
        end
      end

      S_BUSY: begin
        if (ex_busy) begin
          // A branch here is ignored: the EX instruction has not completed.
          {stallF, stallD, stallE} = 3'b111;
          if (to_cnt_q < TO_W'(BUSY_TIMEOUT)) to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_d == TO_W'(BUSY_TIMEOUT)) busy_err_d = 1'b1;
        end else begin
          state_d = S_RUN;
          if (branch_sig) begin
            {flushD, flushE} = 2'b11;
            if (BRANCH_BUBBLES > 0) begin
              state_d   = S_BUBBLE;
              bub_cnt_d = 4'(BRANCH_BUBBLES);
            end
          end
        end
      end

      default: state_d = S_BOOT;
    endcase

    // Reset forces the boot-hold outputs regardless of the current state.
    if (reset) begin
      {stallF, stallD, flushD, flushE} = 4'b1111;
      stallE = 1'b0;
    end

    stall_count_d = stall_count_q + {31'd0, stallF};
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge values computed above.
    if (reset) begin
      state_q       <= S_BOOT;
      boot_cnt_q    <= BOOT_W'(BOOT_CYCLES - 1);
      bub_cnt_q     <= '0;
      to_cnt_q      <= '0;
      busy_err_q    <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      boot_cnt_q    <= boot_cnt_d;
      bub_cnt_q     <= bub_cnt_d;
      to_cnt_q      <= to_cnt_d;
      busy_err_q    <= busy_err_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign busy_err    = busy_err_q;
  assign stall_count = stall_count_q;

endmodule
